// File: rtl/spi_frame_master.sv
// SPI frame master: one BIT_WIDTH-bit word per handshake, SCK idle-high, ENA_n framing the word.
// Define SPI_MASTER_LSB_FIRST_EN to serialise LSB first; the default is MSB first.
module spi_frame_master #(
    parameter int BIT_WIDTH = 32,
    parameter int HALF_DIV  = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic [BIT_WIDTH-1:0] i_TX_DATA,
    input  logic                 i_TX_VALID,
    output logic                 o_TX_READY,
    output logic                 o_SPI_CLK,
    output logic                 o_SPI_ENA_n,
    output logic                 o_SPI_DATA,
    output logic                 o_SPI_DATA_OE,
    output logic                 o_BUSY,
    output logic                 o_DONE
);

    localparam int MAX_CNT = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int BIT_W   = $clog2(BIT_WIDTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [BIT_WIDTH-1:0] shreg, shreg_nxt;
    logic                 sck_nxt, ena_n_nxt, data_nxt, oe_nxt, ready_nxt, busy_nxt, done_nxt;

    // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            o_SPI_CLK     <= 1'b1;
            o_SPI_ENA_n   <= 1'b1;
            o_SPI_DATA    <= 1'b0;
            o_SPI_DATA_OE <= 1'b0;
            o_TX_READY    <= 1'b1;
            o_BUSY        <= 1'b0;
            o_DONE        <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shreg         <= shreg_nxt;
            o_SPI_CLK     <= sck_nxt;
            o_SPI_ENA_n   <= ena_n_nxt;
            o_SPI_DATA    <= data_nxt;
            o_SPI_DATA_OE <= oe_nxt;
            o_TX_READY    <= ready_nxt;
            o_BUSY        <= busy_nxt;
            o_DONE        <= done_nxt;
        end
    end

    // NOTE: every signal gets a hold-value default first, so no path through this block infers a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        sck_nxt     = o_SPI_CLK;
        ena_n_nxt   = o_SPI_ENA_n;
        data_nxt    = o_SPI_DATA;
        oe_nxt      = o_SPI_DATA_OE;
        ready_nxt   = o_TX_READY;
        busy_nxt    = o_BUSY;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_TX_VALID && o_TX_READY) begin
                    shreg_nxt   = i_TX_DATA;
                    bit_cnt_nxt = BIT_LAST;
                    cnt_nxt     = '0;
                    sck_nxt     = 1'b0;
                    ena_n_nxt   = 1'b0;
                    oe_nxt      = 1'b1;
                    ready_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                    data_nxt    = i_TX_DATA[0];
`else
                    data_nxt    = i_TX_DATA[BIT_WIDTH-1];
`endif
                    state_nxt   = LOW;
                end
            end
            LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    sck_nxt   = 1'b1;
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (cnt != HALF_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (bit_cnt != '0) begin
                    // Falling SCK edge launches the next bit; the receiver samples on the rise.
                    cnt_nxt     = '0;
                    sck_nxt     = 1'b0;
                    bit_cnt_nxt = bit_cnt - 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                    shreg_nxt   = shreg >> 1;
                    data_nxt    = shreg[1];
`else
                    shreg_nxt   = shreg << 1;
                    data_nxt    = shreg[BIT_WIDTH-2];
`endif
                    state_nxt   = LOW;
                end else begin
                    cnt_nxt   = '0;
                    ena_n_nxt = 1'b1;
                    oe_nxt    = 1'b0;
                    sck_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: instance 0 uses HALF_DIV=4/GAP_CYC=8, instance 1 uses 1/1.
// A negedge monitor rebuilds each frame from SCK rising edges and compares it with the queued word.
module tb_spi_frame_master;

    localparam int BW = 32;
    localparam int HD [2] = '{4, 1};
    localparam int GC [2] = '{8, 1};

    logic          clk = 1'b0;
    logic [1:0]    rst = 2'b11;
    logic [1:0]    tx_valid = 2'b00;
    logic [BW-1:0] tx_data [2] = '{32'h0, 32'h0};
    logic [1:0]    ready, sck, ena, sdata, oe, busy, done;

    int checks = 0;
    int failures = 0;
    int pcyc = 0;
    int acc_cyc = 0;

    logic [BW-1:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    spi_frame_master #(.BIT_WIDTH(BW), .HALF_DIV(4), .GAP_CYC(8)) dut0 (
        .i_CLK(clk), .i_RESET(rst[0]), .i_TX_DATA(tx_data[0]), .i_TX_VALID(tx_valid[0]),
        .o_TX_READY(ready[0]), .o_SPI_CLK(sck[0]), .o_SPI_ENA_n(ena[0]), .o_SPI_DATA(sdata[0]),
        .o_SPI_DATA_OE(oe[0]), .o_BUSY(busy[0]), .o_DONE(done[0])
    );

    spi_frame_master #(.BIT_WIDTH(BW), .HALF_DIV(1), .GAP_CYC(1)) dut1 (
        .i_CLK(clk), .i_RESET(rst[1]), .i_TX_DATA(tx_data[1]), .i_TX_VALID(tx_valid[1]),
        .o_TX_READY(ready[1]), .o_SPI_CLK(sck[1]), .o_SPI_ENA_n(ena[1]), .o_SPI_DATA(sdata[1]),
        .o_SPI_DATA_OE(oe[1]), .o_BUSY(busy[1]), .o_DONE(done[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word as the receiver reconstructs it when shifting in MSB first.
    function automatic logic [BW-1:0] to_rx(input logic [BW-1:0] w);
        logic [BW-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < BW; i++) r[i] = w[BW-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [1:0]    rst_edge = 2'b11;
    logic [1:0]    sck_prev = 2'b11, ena_prev = 2'b11, ready_prev = 2'b11, done_prev = 2'b00;
    logic [BW-1:0] rx_word [2];
    int            rx_bits [2] = '{0, 0};
    int            ena_len [2], ena_fall [2], last_rise [2], done_cyc [2];
    int            done_cnt [2] = '{0, 0};
    bit            period_bad [2], oe_bad [2], done_pending [2], double_done [2];

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!ena[g] && ena_prev[g]) begin
                rx_word[g] = '0; rx_bits[g] = 0; ena_len[g] = 0;
                ena_fall[g] = pcyc; period_bad[g] = 0;
            end
            if (oe[g] !== !ena[g]) oe_bad[g] = 1;
            if (!ena[g]) begin
                ena_len[g]++;
                if (sck[g] && !sck_prev[g]) begin
                    rx_word[g] = {rx_word[g][BW-2:0], sdata[g]};
                    if (rx_bits[g] == 0) begin
                        if (pcyc - ena_fall[g] != HD[g]) period_bad[g] = 1;
                    end else if (pcyc - last_rise[g] != 2 * HD[g]) begin
                        period_bad[g] = 1;
                    end
                    last_rise[g] = pcyc;
                    rx_bits[g]++;
                end
            end
            if (done[g]) begin
                done_cnt[g]++;
                if (done_prev[g]) double_done[g] = 1;
                done_cyc[g] = pcyc;
                done_pending[g] = 1;
            end
            if (ena[g] && !ena_prev[g]) begin
                if (rst_edge[g]) begin
                    check($sformatf("abort_sck_%0d", g), sck[g], 1'b1);
                    check($sformatf("abort_oe_%0d", g), oe[g], 1'b0);
                    check($sformatf("abort_ready_%0d", g), ready[g], 1'b1);
                    check($sformatf("abort_done_%0d", g), done[g], 1'b0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    done_pending[g] = 0;
                end else begin
                    check($sformatf("frame_expected_%0d", g), exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0)
                        check($sformatf("rx_word_%0d", g), rx_word[g], exp_q.pop_front());
                    check($sformatf("rx_bits_%0d", g), rx_bits[g], BW);
                    check($sformatf("ena_low_len_%0d", g), ena_len[g], 2 * HD[g] * BW);
                    check($sformatf("sck_timing_%0d", g), period_bad[g], 1'b0);
                    check($sformatf("oe_tracks_ena_%0d", g), oe_bad[g], 1'b0);
                    check($sformatf("done_at_end_%0d", g), done[g], 1'b1);
                    check($sformatf("busy_at_done_%0d", g), busy[g], 1'b1);
                end
            end
            if (ready[g] && !ready_prev[g] && !rst_edge[g] && done_pending[g]) begin
                check($sformatf("done_to_ready_%0d", g), pcyc - done_cyc[g], GC[g]);
                check($sformatf("busy_after_gap_%0d", g), busy[g], 1'b0);
                done_pending[g] = 0;
            end
            sck_prev[g] = sck[g]; ena_prev[g] = ena[g];
            ready_prev[g] = ready[g]; done_prev[g] = done[g];
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int g, input logic [BW-1:0] w, input bit hold);
        int n = 0;
        tx_data[g] = w;
        while (!ready[g] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) begin
            check("ready_timeout", ready[g], 1'b1);
            return;
        end
        tx_valid[g] = 1'b1;
        exp_q.push_back(to_rx(w));
        acc_cyc = pcyc;
        @(negedge clk);
        if (!hold) tx_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (!(ready[g] && !busy[g]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", ready[g] && !busy[g], 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bits(input int g, input int b);
        int n = 0;
        while (rx_bits[g] < b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("bits_timeout", rx_bits[g] >= b, 1'b1);
    endtask

    initial begin
        int a1;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_sck_%0d", g), sck[g], 1'b1);
            check($sformatf("rst_ena_%0d", g), ena[g], 1'b1);
            check($sformatf("rst_data_%0d", g), sdata[g], 1'b0);
            check($sformatf("rst_oe_%0d", g), oe[g], 1'b0);
            check($sformatf("rst_ready_%0d", g), ready[g], 1'b1);
            check($sformatf("rst_busy_%0d", g), busy[g], 1'b0);
            check($sformatf("rst_done_%0d", g), done[g], 1'b0);
        end

        send(0, 32'h0300_0100, 0);
        wait_idle(0);

        // Back-to-back with VALID held high.
        send(0, 32'hA5A5_A5A5, 1);
        a1 = acc_cyc;
        send(0, 32'h0000_FFFF, 0);
        check("accept_to_accept", acc_cyc - a1, 1 + 2 * HD[0] * BW + GC[0]);
        wait_idle(0);

        // VALID pulse mid-frame must be ignored; nothing is queued for it.
        send(0, 32'h5A0F_3C96, 0);
        wait_bits(0, 5);
        tx_data[0] = 32'hDEAD_BEEF;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);

        // Reset at bit 10 aborts the frame, then a fresh word goes out.
        send(0, 32'hF00D_CAFE, 0);
        wait_bits(0, 10);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("post_abort_busy", busy[0], 1'b0);
        send(0, 32'h1234_5678, 0);
        wait_idle(0);

        // Bit order: MSB first by default, LSB first under the macro.
        send(0, 32'h0000_0001, 0);
        wait_idle(0);

        // Fastest divider and shortest gap.
        send(1, 32'h8000_0001, 0);
        wait_idle(1);

        check("done_count_0", done_cnt[0], 6);
        check("done_count_1", done_cnt[1], 1);
        check("done_single_0", double_done[0], 1'b0);
        check("done_single_1", double_done[1], 1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
